// File: rtl/i2c_pkg.sv
//==============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and constants for the single-master I2C initiator:
//            FSM state encoding, bit-cell phase encodings, byte width and the
//            default quarter-period divider.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package i2c_pkg;

    // Bits per transferred byte (address+R/W or data)
    localparam int I2C_BITS     = 8;

    // Default clk cycles per quarter SCL period (100 MHz -> 100 kHz SCL)
    localparam int QDIV_DEFAULT = 250;

    // Bit-cell phases: Q0 SDA changes, Q1 SCL rises, Q2 SCL high + sample, Q3 SCL low
    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_AACK  = 4'd3,
        S_WDATA = 4'd4,
        S_WACK  = 4'd5,
        S_RDATA = 4'd6,
        S_MNACK = 4'd7,
        S_STOP  = 4'd8
    } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_qtick_gen.sv
//==============================================================================
// Module   : i2c_qtick_gen
// Brief    : Quarter-period tick generator. Counts QDIV clk cycles per quarter
//            and steps a 2-bit phase (Q0..Q3) on each tick. Clear restarts the
//            cell at Q0; freeze holds counter and phase (SCL stretching).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int QDIV  = QDIV_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       freeze_i,
    output logic       qtick_o,
    output logic [1:0] phase_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QDIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    assign qtick_o = en_i & ~clr_i & ~freeze_i & (cnt_q == CNT_MAX);
    assign phase_o = phase_q;

    // Next counter/phase: clear wins, otherwise count while enabled and not frozen
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = PH_Q0;
        end else if (en_i && !freeze_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= PH_Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master.sv
//==============================================================================
// Module   : i2c_master
// Brief    : Single-master I2C initiator. One command = START, 7-bit address
//            + R/W, one data byte, ACK/NACK, STOP. Open-drain SDA.
//            Optional feature macro: I2C_CLK_STRETCH_EN (open-drain SCL with
//            synchronised readback; slave clock stretching honoured).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_master
    import i2c_pkg::*;
#(
    parameter int QDIV  = QDIV_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_addr_i,
    input  logic       cmd_rw_i,
    input  logic [7:0] cmd_wdata_i,
    output logic [7:0] rdata_o,
    output logic       done_o,
    output logic       addr_nack_o,
    output logic       data_nack_o,
    output logic       busy_o,
`ifdef I2C_CLK_STRETCH_EN
    inout  wire        scl_io,
`else
    output logic       scl_o,
`endif
    inout  wire        sda_io
);

    localparam logic [2:0] LAST_BIT = 3'(I2C_BITS - 1);

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        addr_nack_q, addr_nack_d;
    logic        data_nack_q, data_nack_d;
    logic        samp_q, samp_d;
    logic [1:0]  sda_sync_q;

    logic        w_qtick, w_freeze, w_accept, w_cell_end, w_sample;
    logic        w_scl_hi, w_sda_low, w_sda_s;
    logic [1:0]  w_phase;

    assign w_accept   = cmd_valid_i & (state_q == S_IDLE);
    assign w_cell_end = w_qtick & (w_phase == PH_Q3);
    assign w_sample   = w_qtick & (w_phase == PH_Q2);
    assign w_sda_s    = sda_sync_q[1];

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign addr_nack_o = addr_nack_q;
    assign data_nack_o = data_nack_q;

    // SDA is open drain: only ever pulled low or released
    assign sda_io = w_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync_q;

    assign scl_io   = w_scl_hi ? 1'bz : 1'b0;
    // Hold the cell while SCL is released during the high phases but a slave keeps it low
    assign w_freeze = ((w_phase == PH_Q1) || (w_phase == PH_Q2)) & w_scl_hi & ~scl_sync_q[1];

    // SCL readback synchroniser
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) scl_sync_q <= 2'b11;
        else         scl_sync_q <= {scl_sync_q[0], scl_io};
    end
`else
    assign scl_o    = w_scl_hi;
    assign w_freeze = 1'b0;
`endif

    i2c_qtick_gen #(
        .QDIV  (QDIV),
        .CNT_W (CNT_W)
    ) u_qtick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (busy_o),
        .clr_i    (w_accept),
        .freeze_i (w_freeze),
        .qtick_o  (w_qtick),
        .phase_o  (w_phase)
    );

    // SDA input synchroniser
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sda_sync_q <= 2'b11;
        else         sda_sync_q <= {sda_sync_q[0], sda_io};
    end

    // Next-state logic plus bus drive; all decisions happen on phase ticks
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        addr_nack_d = addr_nack_q;
        data_nack_d = data_nack_q;
        samp_d      = w_sample ? w_sda_s : samp_q;
        w_scl_hi    = 1'b1;
        w_sda_low   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d     = S_START;
                    sh_d        = {cmd_addr_i, cmd_rw_i};
                    rw_d        = cmd_rw_i;
                    wdata_d     = cmd_wdata_i;
                    bit_cnt_d   = '0;
                    addr_nack_d = 1'b0;
                    data_nack_d = 1'b0;
                end
            end
            S_START: begin
                w_scl_hi  = (w_phase == PH_Q0) || (w_phase == PH_Q1);
                w_sda_low = (w_phase != PH_Q0);
                if (w_cell_end) begin
                    state_d   = S_ADDR;
                    bit_cnt_d = '0;
                end
            end
            S_ADDR, S_WDATA: begin
                w_scl_hi  = (w_phase == PH_Q1) || (w_phase == PH_Q2);
                w_sda_low = ~sh_q[7];
                if (w_cell_end) begin
                    sh_d      = {sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT)
                        state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                end
            end
            S_AACK: begin
                w_scl_hi = (w_phase == PH_Q1) || (w_phase == PH_Q2);
                if (w_cell_end) begin
                    if (samp_q) begin
                        addr_nack_d = 1'b1;
                        state_d     = S_STOP;
                    end else if (rw_q) begin
                        state_d     = S_RDATA;
                    end else begin
                        sh_d        = wdata_q;
                        state_d     = S_WDATA;
                    end
                end
            end
            S_WACK: begin
                w_scl_hi = (w_phase == PH_Q1) || (w_phase == PH_Q2);
                if (w_cell_end) begin
                    data_nack_d = samp_q;
                    state_d     = S_STOP;
                end
            end
            S_RDATA: begin
                w_scl_hi = (w_phase == PH_Q1) || (w_phase == PH_Q2);
                if (w_sample)
                    sh_d = {sh_q[6:0], w_sda_s};
                if (w_cell_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        rdata_d = sh_q;
                        state_d = S_MNACK;
                    end
                end
            end
            S_MNACK: begin
                w_scl_hi = (w_phase == PH_Q1) || (w_phase == PH_Q2);
                if (w_cell_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                w_scl_hi  = (w_phase != PH_Q0);
                w_sda_low = (w_phase == PH_Q0) || (w_phase == PH_Q1);
                if (w_cell_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, shift and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            addr_nack_q <= 1'b0;
            data_nack_q <= 1'b0;
            samp_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            addr_nack_q <= addr_nack_d;
            data_nack_q <= data_nack_d;
            samp_q      <= samp_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
//==============================================================================
// Module   : tb_i2c_master
// Brief    : Self-checking bench for i2c_master with a behavioural 7-bit
//            slave at 7'b1010101 (ACKs its address, NACKs write data, returns
//            its LED byte on reads). Optional: I2C_CLK_STRETCH_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_master;

    localparam int         QDIV     = 4;
    localparam logic [6:0] SLV_ADDR = 7'b1010101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] rdata;
    logic       done, addr_nack, data_nack, busy;
    wire        scl;
    wire        sda;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int base_cyc = 0;

    // Behavioural slave / bus monitor state
    logic       sb_active = 1'b0;
    logic       sb_sel = 1'b0;
    logic       sb_rd = 1'b0;
    logic       sb_drv = 1'b0;
    logic [7:0] sb_sh = '0;
    logic [7:0] led = '0;
    int         sb_bit = 0;
    int         sb_byte = 0;
    logic [7:0] bus_q[$];
    logic       ack_q[$];

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = sb_drv ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
    logic s_scl_low = 1'b0;
    logic stretch_on = 1'b0;
    pullup (scl);
    assign scl = s_scl_low ? 1'b0 : 1'bz;
`endif

    i2c_master #(.QDIV(QDIV), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_rw_i    (cmd_rw),
        .cmd_wdata_i (cmd_wdata),
        .rdata_o     (rdata),
        .done_o      (done),
        .addr_nack_o (addr_nack),
        .data_nack_o (data_nack),
        .busy_o      (busy),
`ifdef I2C_CLK_STRETCH_EN
        .scl_io      (scl),
`else
        .scl_o       (scl),
`endif
        .sda_io      (sda)
    );

    always @(posedge clk) if (rst_n && done === 1'b1) done_cnt++;

    // START / STOP detection
    always @(negedge sda) if (scl === 1'b1) begin
        sb_active = 1'b1; sb_bit = 0; sb_byte = 0; sb_drv = 1'b0;
    end
    always @(posedge sda) if (scl === 1'b1) begin
        sb_active = 1'b0; sb_drv = 1'b0;
    end

    // Slave sampling on SCL rise
    always @(posedge scl) if (sb_active) begin
        if (sb_bit < 8) begin
            sb_sh = {sb_sh[6:0], sda};
            sb_bit++;
            if (sb_bit == 8) begin
                bus_q.push_back(sb_sh);
                if (sb_byte == 0) begin
                    sb_sel = (sb_sh[7:1] == SLV_ADDR);
                    sb_rd  = sb_sh[0];
                end else if (sb_sel && !sb_rd) begin
                    led = sb_sh;
                end
            end
        end else begin
            ack_q.push_back(sda);
            sb_bit = 0;
            sb_byte++;
        end
    end

    // Slave drive on SCL fall: address ACK, data NACK, read data
    always @(negedge scl) if (sb_active) begin
        sb_drv = 1'b0;
        if (sb_bit == 8)
            sb_drv = (sb_byte == 0) && sb_sel;
        else if (sb_byte == 1 && sb_sel && sb_rd)
            sb_drv = ~led[7 - sb_bit];
`ifdef I2C_CLK_STRETCH_EN
        if (stretch_on && sb_byte == 0 && sb_bit == 5) begin
            fork
                begin
                    s_scl_low = 1'b1;
                    repeat (2 * QDIV + 20) @(posedge clk);
                    s_scl_low = 1'b0;
                end
            join_none
        end
`endif
    end

    task automatic clear_mon();
        bus_q.delete();
        ack_q.delete();
        done_cnt = 0;
    endtask

    // Issue one command from a negedge and wait (bounded) for done
    task automatic do_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          output int cyc, output bit ok);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; ok = 1'b0;
        while (cyc < 3000) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_in_scl: got %b want 1", scl); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if ({addr_nack, data_nack} !== 2'b00) begin n_fail++; $display("FAIL reset_nack: got %b want 00", {addr_nack, data_nack}); end
    endtask

    task automatic test_write();
        int cyc; bit ok;
        clear_mon();
        do_cmd(7'h55, 1'b0, 8'hA5, cyc, ok);
        base_cyc = cyc;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_done_timeout: got none want done"); end
        n_cmp++; if (bus_q.size() !== 2) begin n_fail++; $display("FAIL wr_nbytes: got %0d want 2", bus_q.size()); end
        if (bus_q.size() == 2) begin
            n_cmp++; if (bus_q[0] !== 8'hAA) begin n_fail++; $display("FAIL wr_byte0: got %h want AA", bus_q[0]); end
            n_cmp++; if (bus_q[1] !== 8'hA5) begin n_fail++; $display("FAIL wr_byte1: got %h want A5", bus_q[1]); end
        end
        n_cmp++; if (led !== 8'hA5) begin n_fail++; $display("FAIL wr_led: got %h want A5", led); end
        n_cmp++; if (addr_nack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_nack: got %b want 0", addr_nack); end
        n_cmp++; if (data_nack !== 1'b1) begin n_fail++; $display("FAIL wr_data_nack: got %b want 1", data_nack); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wr_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_addr_nack();
        int cyc; bit ok;
        clear_mon();
        do_cmd(7'h12, 1'b0, 8'h77, cyc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL an_done_timeout: got none want done"); end
        n_cmp++; if (addr_nack !== 1'b1) begin n_fail++; $display("FAIL an_addr_nack: got %b want 1", addr_nack); end
        n_cmp++; if (data_nack !== 1'b0) begin n_fail++; $display("FAIL an_data_nack: got %b want 0", data_nack); end
        n_cmp++; if (bus_q.size() !== 1) begin n_fail++; $display("FAIL an_nbytes: got %0d want 1", bus_q.size()); end
        if (bus_q.size() >= 1) begin
            n_cmp++; if (bus_q[0] !== 8'h24) begin n_fail++; $display("FAIL an_byte0: got %h want 24", bus_q[0]); end
        end
        n_cmp++; if (led !== 8'hA5) begin n_fail++; $display("FAIL an_led: got %h want A5", led); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL an_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_read();
        int cyc; bit ok;
        do_cmd(7'h55, 1'b0, 8'h3C, cyc, ok);
        clear_mon();
        do_cmd(7'h55, 1'b1, 8'h00, cyc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_done_timeout: got none want done"); end
        n_cmp++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_rdata: got %h want 3C", rdata); end
        n_cmp++; if ({addr_nack, data_nack} !== 2'b00) begin n_fail++; $display("FAIL rd_nacks: got %b want 00", {addr_nack, data_nack}); end
        n_cmp++; if (bus_q.size() !== 2) begin n_fail++; $display("FAIL rd_nbytes: got %0d want 2", bus_q.size()); end
        if (bus_q.size() == 2) begin
            n_cmp++; if (bus_q[0] !== 8'hAB) begin n_fail++; $display("FAIL rd_byte0: got %h want AB", bus_q[0]); end
        end
        n_cmp++; if (ack_q.size() !== 2) begin n_fail++; $display("FAIL rd_nacks_seen: got %0d want 2", ack_q.size()); end
        if (ack_q.size() == 2) begin
            n_cmp++; if (ack_q[0] !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", ack_q[0]); end
            n_cmp++; if (ack_q[1] !== 1'b1) begin n_fail++; $display("FAIL rd_master_nack: got %b want 1", ack_q[1]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rd_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_busy_ignore();
        int n;
        clear_mon();
        cmd_addr = 7'h55; cmd_rw = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bi_ready_busy: got %b want 0", cmd_ready); end
        cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'hFF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        n_cmp++; if (n >= 3000) begin n_fail++; $display("FAIL bi_done_timeout: got none want done"); end
        repeat (300) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bi_busy_after: got %b want 0", busy); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bi_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (bus_q.size() !== 2) begin n_fail++; $display("FAIL bi_nbytes: got %0d want 2", bus_q.size()); end
        if (bus_q.size() == 2) begin
            n_cmp++; if (bus_q[0] !== 8'hAA) begin n_fail++; $display("FAIL bi_byte0: got %h want AA", bus_q[0]); end
            n_cmp++; if (bus_q[1] !== 8'h11) begin n_fail++; $display("FAIL bi_byte1: got %h want 11", bus_q[1]); end
        end
        n_cmp++; if (led !== 8'h11) begin n_fail++; $display("FAIL bi_led: got %h want 11", led); end
    endtask

    task automatic test_reset_mid();
        int n, cyc; bit ok;
        clear_mon();
        cmd_addr = 7'h55; cmd_rw = 1'b0; cmd_wdata = 8'h96; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(sb_byte == 1 && sb_bit == 3) && n < 3000) begin @(negedge clk); n++; end
        n_cmp++; if (n >= 3000) begin n_fail++; $display("FAIL rm_reach_bit3: got timeout want WDATA bit 3"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rm_scl: got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rm_sda: got %b want 1", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rm_rdata: got %h want 00", rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d want 0", done_cnt); end
        do_cmd(7'h55, 1'b0, 8'h5A, cyc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rm_next_timeout: got none want done"); end
        n_cmp++; if (led !== 8'h5A) begin n_fail++; $display("FAIL rm_next_led: got %h want 5A", led); end
        n_cmp++; if (data_nack !== 1'b1) begin n_fail++; $display("FAIL rm_next_dnack: got %b want 1", data_nack); end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        int cyc; bit ok;
        clear_mon();
        stretch_on = 1'b1;
        do_cmd(7'h55, 1'b0, 8'hC3, cyc, ok);
        stretch_on = 1'b0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL st_done_timeout: got none want done"); end
        n_cmp++; if (led !== 8'hC3) begin n_fail++; $display("FAIL st_led: got %h want C3", led); end
        if (bus_q.size() >= 1) begin
            n_cmp++; if (bus_q[0] !== 8'hAA) begin n_fail++; $display("FAIL st_byte0: got %h want AA", bus_q[0]); end
        end
        n_cmp++; if (cyc < base_cyc + 20 || cyc > base_cyc + 30) begin
            n_fail++; $display("FAIL st_len: got %0d cycles want %0d..%0d", cyc, base_cyc + 20, base_cyc + 30);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_busy_ignore();
        test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
